// File: rtl/neurocore_pkg.sv
// Constants and state encoding shared by the NeuralChip UART transmitter and receiver.
package neurocore_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/tx_byte_fifo.sv
// First-word-fall-through byte FIFO between the result path and the UART serializer.
module tx_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/uart_result_tx.sv
// 8N1 UART transmitter for matrix-multiply results, LSB first, fed through a small byte FIFO.
module uart_result_tx
    import neurocore_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic       TXD,
    output logic       TX_BUSY,
    output logic       TX_DONE
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t     state;
    tx_state_t     state_n;
    logic [15:0]   baud_cnt;
    logic [15:0]   baud_cnt_n;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_n;
    logic [7:0]    shift_reg;
    logic [7:0]    shift_reg_n;
    logic          line;
    logic          line_n;
    logic          done_pulse;
    logic          done_pulse_n;
    logic          busy;
    logic          busy_n;

    logic          push;
    logic          pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_n;
    logic          bit_last;
    logic          done_point;

    assign TX_READY = !fifo_full;
    assign push     = TX_VALID && TX_READY;

    tx_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (push),
        .pop   (pop),
        .din   (TX_DATA),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bit_last   = (baud_cnt == 16'(CLKS_PER_BIT - 1));
    // TX_DONE is registered, so it is raised one cycle early to land in the last stop cycle.
    assign done_point = (baud_cnt == 16'(CLKS_PER_BIT - 2));

    always_comb begin
        state_n      = state;
        baud_cnt_n   = baud_cnt + 16'd1;
        bit_idx_n    = bit_idx;
        shift_reg_n  = shift_reg;
        line_n       = line;
        done_pulse_n = 1'b0;
        pop          = 1'b0;

        case (state)
            IDLE: begin
                baud_cnt_n = '0;
                line_n     = 1'b1;
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    shift_reg_n = fifo_dout;
                    line_n      = 1'b0;
                    bit_idx_n   = '0;
                    state_n     = START;
                end
            end
            START: begin
                if (bit_last) begin
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    line_n     = shift_reg[0];
                    state_n    = DATA;
                end
            end
            DATA: begin
                if (bit_last) begin
                    baud_cnt_n = '0;
                    if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
                        line_n  = 1'b1;
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        line_n    = shift_reg[bit_idx + 3'd1];
                    end
                end
            end
            STOP: begin
                done_pulse_n = done_point;
                if (bit_last) begin
                    baud_cnt_n = '0;
                    // Chain straight into the next frame when more bytes are waiting.
                    if (!fifo_empty) begin
                        pop         = 1'b1;
                        shift_reg_n = fifo_dout;
                        line_n      = 1'b0;
                        bit_idx_n   = '0;
                        state_n     = START;
                    end else begin
                        line_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                line_n  = 1'b1;
                state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        count_n = fifo_count;
        if (push && !pop) count_n = fifo_count + 1'b1;
        if (pop && !push) count_n = fifo_count - 1'b1;
        busy_n = (state_n != IDLE) || (count_n != '0);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            line       <= 1'b1;
            done_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            baud_cnt   <= baud_cnt_n;
            bit_idx    <= bit_idx_n;
            line       <= line_n;
            done_pulse <= done_pulse_n;
            busy       <= busy_n;
        end
    end

    always_ff @(posedge CLK) begin
        shift_reg <= shift_reg_n;
    end

    assign TXD     = line;
    assign TX_DONE = done_pulse;
    assign TX_BUSY = busy;

endmodule

// File: tb/tb_uart_result_tx.sv
// Directed bench for uart_result_tx at CLKS_PER_BIT=4 with a line-decoding UART model.
module tb_uart_result_tx;

    logic       CLK;
    logic       RESET;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY;
    logic       TXD;
    logic       TX_BUSY;
    logic       TX_DONE;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int         mon_cnt  = -1;
    logic [7:0] mon_byte = '0;
    int         ferr     = 0;
    int         done_err = 0;
    logic [7:0] rx_q [$];
    logic [7:0] exp_q [$];
    int         done_q [$];

    uart_result_tx #(
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .TX_DATA  (TX_DATA),
        .TX_VALID (TX_VALID),
        .TX_READY (TX_READY),
        .TXD      (TXD),
        .TX_BUSY  (TX_BUSY),
        .TX_DONE  (TX_DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Line model: start detected at count 0, bits sampled mid-bit, TX_DONE expected at count 39.
    always @(posedge CLK) begin
        #1;
        if (RESET === 1'b1) begin
            mon_cnt = -1;
        end else begin
            if (mon_cnt >= 0) mon_cnt++;
            else if (TXD === 1'b0) mon_cnt = 0;
            if (TX_DONE === 1'b1) begin
                done_q.push_back(cyc);
                if (mon_cnt != 39) done_err++;
            end
            if (mon_cnt == 2 && TXD !== 1'b0) begin
                ferr++;
                mon_cnt = -1;
            end else if (mon_cnt >= 6 && mon_cnt <= 34 && (mon_cnt % 4) == 2) begin
                mon_byte[(mon_cnt - 6) / 4] = TXD;
            end else if (mon_cnt == 38) begin
                if (TXD !== 1'b1) ferr++;
                else rx_q.push_back(mon_byte);
            end
            if (mon_cnt == 39) mon_cnt = -1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag, input int maxc);
        int n;
        n = 0;
        while (TX_BUSY !== 1'b0 && n < maxc) begin
            tick();
            n++;
        end
        chk(tag, TX_BUSY, 0);
        tick();
        tick();
    endtask

    task automatic check_rx(input string tag);
        int bad;
        int lim;
        bad = 0;
        chk({tag, "_count"}, rx_q.size(), exp_q.size());
        lim = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < lim; i++)
            if (rx_q[i] !== exp_q[i]) bad++;
        chk({tag, "_order"}, bad, 0);
    endtask

    task automatic clear_logs();
        rx_q.delete();
        exp_q.delete();
        done_q.delete();
    endtask

    initial begin
        int         bad;
        int         dcnt;
        int         dpos;
        logic       busy39;
        logic       exp_bit;
        logic [7:0] b;
        int         t_fall;
        int         acc [6];
        int         idx;
        int         e;
        logic       rdy_e4;
        logic       rdy_e41;
        logic       rdy_now;
        int         lows;
        int         gap;
        int         k;
        int         tmo;

        RESET    = 1'b1;
        TX_VALID = 1'b0;
        TX_DATA  = 8'h00;

        // Reset idle
        tick(); tick(); tick();
        RESET = 1'b0;
        chk("rst_txd",   TXD,      1);
        chk("rst_ready", TX_READY, 1);
        chk("rst_busy",  TX_BUSY,  0);
        chk("rst_done",  TX_DONE,  0);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (TXD !== 1'b1 || TX_READY !== 1'b1 || TX_BUSY !== 1'b0 || TX_DONE !== 1'b0) bad++;
        end
        chk("idle_50", bad, 0);

        // Single byte 0xA5
        clear_logs();
        b = 8'hA5;
        exp_q.push_back(b);
        TX_VALID = 1'b1;
        TX_DATA  = b;
        tick();
        TX_VALID = 1'b0;
        TX_DATA  = 8'hFF;
        chk("a5_txd_accept",  TXD,     1);
        chk("a5_busy_accept", TX_BUSY, 1);
        tick();
        bad = 0; dcnt = 0; dpos = -1; busy39 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i < 4)        exp_bit = 1'b0;
            else if (i >= 36) exp_bit = 1'b1;
            else              exp_bit = b[(i / 4) - 1];
            if (TXD !== exp_bit) bad++;
            if (TX_DONE === 1'b1) begin
                dcnt++;
                dpos = i;
            end
            if (i == 39) busy39 = TX_BUSY;
            tick();
        end
        chk("a5_line",     bad,    0);
        chk("a5_done_cnt", dcnt,   1);
        chk("a5_done_pos", dpos,   39);
        chk("a5_busy_39",  busy39, 1);
        chk("a5_busy_end", TX_BUSY, 0);
        chk("a5_done_end", TX_DONE, 0);
        chk("a5_txd_end",  TXD,     1);
        check_rx("a5_rx");

        // Back-to-back 0x00, 0xFF, 0x3C
        clear_logs();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h3C);
        TX_VALID = 1'b1;
        TX_DATA  = 8'h00;
        tick();
        TX_DATA = 8'hFF;
        tick();
        t_fall = cyc;
        chk("b2b_fall", TXD, 0);
        TX_DATA = 8'h3C;
        tick();
        TX_VALID = 1'b0;
        wait_idle("b2b_idle", 300);
        chk("b2b_done_cnt", done_q.size(), 3);
        if (done_q.size() == 3) begin
            chk("b2b_done0", done_q[0] - t_fall, 39);
            chk("b2b_gap01", done_q[1] - done_q[0], 40);
            chk("b2b_gap12", done_q[2] - done_q[1], 40);
        end
        check_rx("b2b_rx");

        // Full FIFO with 0x01..0x06 held on TX_VALID
        clear_logs();
        for (int i = 1; i <= 6; i++) exp_q.push_back(8'(i));
        for (int i = 0; i < 6; i++) acc[i] = -1;
        idx = 0; e = 0; rdy_e4 = 1'b1; rdy_e41 = 1'b0;
        TX_VALID = 1'b1;
        TX_DATA  = 8'h01;
        while (e < 200 && (idx < 6 || e <= 41)) begin
            rdy_now = TX_VALID && TX_READY;
            tick();
            if (rdy_now) begin
                acc[idx] = e;
                idx++;
                TX_DATA = 8'(idx + 1);
                if (idx == 6) TX_VALID = 1'b0;
            end
            if (e == 4)  rdy_e4  = TX_READY;
            if (e == 41) rdy_e41 = TX_READY;
            e++;
        end
        TX_VALID = 1'b0;
        chk("full_acc1", acc[0], 0);
        chk("full_acc2", acc[1], 1);
        chk("full_acc5", acc[4], 4);
        chk("full_ready_low",  rdy_e4,  0);
        chk("full_ready_back", rdy_e41, 1);
        chk("full_acc6", acc[5], 42);
        wait_idle("full_idle", 400);
        chk("full_done_cnt", done_q.size(), 6);
        check_rx("full_rx");

        // Reset during bit 3 of frame 1
        clear_logs();
        TX_VALID = 1'b1;
        TX_DATA  = 8'h81;
        tick();
        TX_DATA = 8'h7E;
        tick();
        TX_VALID = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        RESET = 1'b1;
        tick();
        chk("mid_rst_txd",   TXD,      1);
        chk("mid_rst_done",  TX_DONE,  0);
        chk("mid_rst_busy",  TX_BUSY,  0);
        chk("mid_rst_ready", TX_READY, 1);
        RESET = 1'b0;
        lows = 0; dcnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (TXD === 1'b0) lows++;
            if (TX_DONE === 1'b1) dcnt++;
        end
        chk("mid_no_frame", lows, 0);
        chk("mid_no_done",  dcnt, 0);
        check_rx("mid_rx");

        clear_logs();
        exp_q.push_back(8'h55);
        TX_VALID = 1'b1;
        TX_DATA  = 8'h55;
        tick();
        TX_VALID = 1'b0;
        wait_idle("after_rst_idle", 100);
        chk("after_rst_done", done_q.size(), 1);
        check_rx("after_rst_rx");

        // Random stress
        clear_logs();
        tmo = 0;
        for (int n = 0; n < 200; n++) begin
            gap = (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : 0);
            TX_VALID = 1'b0;
            for (int g = 0; g < gap; g++) tick();
            b = 8'($urandom);
            exp_q.push_back(b);
            TX_VALID = 1'b1;
            TX_DATA  = b;
            k = 0;
            while (TX_READY !== 1'b1 && k < 100) begin
                tick();
                k++;
            end
            if (k >= 100) tmo++;
            tick();
        end
        TX_VALID = 1'b0;
        wait_idle("rand_idle", 400);
        chk("rand_timeouts", tmo, 0);
        chk("rand_done_cnt", done_q.size(), 200);
        check_rx("rand_rx");
        chk("framing_errors", ferr, 0);
        chk("done_alignment", done_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_result_tx.md
# uart_result_tx

UART transmitter on the TXD side of NeuralChip. It serializes bytes from the matrix-multiply result path into 8N1 frames, LSB first. A 4-entry byte FIFO decouples the producer from the line rate. It is the transmit counterpart of the chip's RXD receiver and runs at the same bit period.

## Interface
- CLKS_PER_BIT, default 87: clock cycles per UART bit (10 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, default 4: byte FIFO entries; power of two, at least 2.
- CLK  in  1  system clock; the single clock domain.
- RESET  in  1  synchronous, active-high reset.
- TX_DATA  in  8  byte to transmit.
- TX_VALID  in  1  producer has a byte on TX_DATA.
- TX_READY  out  1  FIFO can accept; a byte transfers on a rising edge where TX_VALID and TX_READY are both high.
- TXD  out  1  serial line; idles high.
- TX_BUSY  out  1  frame in progress or FIFO non-empty.
- TX_DONE  out  1  one-cycle pulse at the end of each stop bit.

## Operation
- Reset values: TXD=1, TX_READY=1, TX_BUSY=0, TX_DONE=0. FIFO is empty, state is IDLE, and all counters are 0.
- All outputs are registered except TX_READY. TX_READY = !full, decoded from the registered count.
- FIFO:
  - Push on TX_VALID && TX_READY.
  - Pop only when the serializer loads a byte.
  - Pointers wrap modulo FIFO_DEPTH. The count has log2(FIFO_DEPTH)+1 bits.
  - Push while full is impossible because TX_READY is low.
  - Push and pop in the same cycle leave the count unchanged.
- Serializer FSM:
  - IDLE: TXD=1. If the FIFO is non-empty: pop into the shift register, set TXD=0, go to START.
  - START: hold the start bit for CLKS_PER_BIT cycles, then output bit 0 and go to DATA.
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. After bit 7, set TXD=1 and go to STOP.
  - STOP: hold high for CLKS_PER_BIT cycles. On the last cycle, pulse TX_DONE.
    - If the FIFO is non-empty, pop, set TXD=0 and go to START. There is no idle gap between frames.
    - Otherwise go to IDLE.
- Counters:
  - Baud counter is 16 bits. It counts 0..CLKS_PER_BIT-1 and clears on every state or bit change.
  - Bit index is 3 bits.
- TX_DATA is sampled only at push. Later changes on TX_DATA do not affect queued bytes.
- TX_BUSY = (state != IDLE) || (count != 0).
- RESET asserted mid-frame:
  - On the next edge TXD=1 and the FIFO is flushed; queued bytes are lost.
  - A truncated frame is acceptable. The receiver sees it as a framing error.
  - TX_DONE does not pulse for the aborted frame.

## Timing
- Byte accepted at edge E0 into an empty FIFO with state IDLE: the pop and TXD falling occur at E1, so the start bit begins 1 cycle after acceptance.
- Frame length is exactly 10*CLKS_PER_BIT cycles, measured from TXD falling to the end of the stop bit.
- Bit k (k=0..7) occupies cycles [(k+1)*CLKS_PER_BIT, (k+2)*CLKS_PER_BIT) relative to TXD falling.
- TX_DONE is high in the last cycle of the stop bit, i.e. cycle 10*CLKS_PER_BIT-1 relative to TXD falling.
- Back-to-back bytes: the next start bit begins on the cycle immediately after the previous TX_DONE cycle.
- TX_READY:
  - Falls in the cycle after the push that fills the FIFO.
  - Rises in the cycle after the pop that frees a slot.

## Structure
- Shared package neurocore_pkg holds:
  - the state typedef tx_state_t {IDLE, START, DATA, STOP};
  - UART_DATA_BITS=8;
  - UART_FRAME_BITS=10.
  - The receiver reuses the same constants.
- Sub-module tx_byte_fifo, parameterized by depth and width:
  - ports: push, pop, din, dout, full, empty, count;
  - synchronous active-high reset, first-word-fall-through.
- The serializer FSM lives in uart_result_tx itself.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset idle: hold RESET 3 cycles, release. TXD=1, TX_READY=1, TX_BUSY=0 and TX_DONE=0 for 50 cycles.
- Single byte 0xA5:
  - TXD falls 1 cycle after acceptance.
  - Line reads 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles wide.
  - TX_DONE pulses once at cycle 39 after TXD falls.
  - TX_BUSY clears the cycle after.
- Back-to-back 0x00, 0xFF, 0x3C pushed on consecutive cycles:
  - Three frames with no idle cycles between them.
  - Exactly three TX_DONE pulses, 40 cycles apart.
- Full FIFO: hold TX_VALID with bytes 0x01..0x06.
  - 0x01 is popped into the serializer one cycle after it is accepted; then the FIFO fills with 0x02..0x05.
  - TX_READY drops after 0x05 and 0x06 stalls.
  - TX_READY returns the cycle after the pop at the end of frame 1; 0x06 is accepted next.
  - Output order is 0x01..0x06, none lost or duplicated.
- Reset mid-frame: push 0x81, 0x7E; assert RESET during bit 3 of frame 1.
  - TXD=1 next cycle, no TX_DONE, 0x7E never transmitted.
  - After release, a push of 0x55 transmits correctly.
- Random stress: 200 random bytes with random TX_VALID gaps.
  - A bench UART model decodes identical data in order.
  - The model sees no framing errors.
